pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : Next-PC selection with call/return stack and fault pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
    parameter int              AW        = 32,
    parameter int              JW        = 26,
    parameter int              RAS_DEPTH = 4,
    parameter logic [AW-1:0]   RESET_VEC = '0,
    parameter logic [AW-1:0]   TRAP_VEC  = '1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [3:0]    pc_control,
    input  logic [JW-1:0] jump_address,
    input  logic [15:0]   branch_offset,
    input  logic          branch_taken,
    input  logic [AW-1:0] reg_address,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] link_addr,
    output logic          ras_overflow,
    output logic          ras_underflow,
    output logic          misalign,
    output logic          illegal
);

    localparam int         PW           = $clog2(RAS_DEPTH);
    localparam logic [PW:0] c_full_count = (PW+1)'(RAS_DEPTH);

    localparam logic [3:0] c_SEQ    = 4'b0000;
    localparam logic [3:0] c_REG    = 4'b0001;
    localparam logic [3:0] c_JUMP   = 4'b0010;
    localparam logic [3:0] c_BRANCH = 4'b0011;
    localparam logic [3:0] c_CALL   = 4'b0100;
    localparam logic [3:0] c_RET    = 4'b0101;
    localparam logic [3:0] c_HOLD   = 4'b0110;

    logic [AW-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0] r_top;
    logic [PW:0]   r_count;

    logic [AW-1:0] w_seq;
    logic [AW-1:0] w_reg_target;
    logic [AW-1:0] w_jump_target;
    logic [AW-1:0] w_boff_ext;
    logic [AW-1:0] w_branch_target;
    logic [PW-1:0] w_top_inc;
    logic          w_push;

    assign w_seq           = pc + AW'(4);
    assign w_reg_target    = {reg_address[AW-1:2], 2'b00};
    assign w_boff_ext      = AW'($signed(branch_offset));
    assign w_branch_target = w_seq + (w_boff_ext << 2);
    assign w_top_inc       = r_top + PW'(1);
    assign w_push          = en && !rst && (pc_control == c_CALL);

    generate
        if (JW + 2 == AW) begin : g_full_jump
            assign w_jump_target = {jump_address, 2'b00};
        end else begin : g_part_jump
            assign w_jump_target = {pc[AW-1:JW+2], jump_address, 2'b00};
        end
    endgenerate

    // Entries carry no reset; they are only read while r_count is non-zero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ras[w_top_inc] <= w_seq;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_VEC;
            link_addr     <= '0;
            r_top         <= '0;
            r_count       <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
            misalign      <= 1'b0;
            illegal       <= 1'b0;
        end else begin
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
            misalign      <= 1'b0;
            illegal       <= 1'b0;
            if (en) begin
                case (pc_control)
                    c_SEQ:    pc <= w_seq;
                    c_REG: begin
                        pc       <= w_reg_target;
                        misalign <= |reg_address[1:0];
                    end
                    c_JUMP:   pc <= w_jump_target;
                    c_BRANCH: pc <= branch_taken ? w_branch_target : w_seq;
                    c_CALL: begin
                        // A full stack wraps onto its oldest entry; count saturates.
                        pc        <= w_jump_target;
                        link_addr <= w_seq;
                        r_top     <= w_top_inc;
                        if (r_count == c_full_count) begin
                            ras_overflow <= 1'b1;
                        end else begin
                            r_count <= r_count + (PW+1)'(1);
                        end
                    end
                    c_RET: begin
                        if (r_count == '0) begin
                            pc            <= w_reg_target;
                            ras_underflow <= 1'b1;
                        end else begin
                            pc      <= r_ras[r_top];
                            r_top   <= r_top - PW'(1);
                            r_count <= r_count - (PW+1)'(1);
                        end
                    end
                    c_HOLD:   pc <= pc;
                    default: begin
                        pc      <= TRAP_VEC;
                        illegal <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire
